exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Two-pass micro-sequencer for a small subset of x86 stack/move opcodes.
//   An opcode byte is accepted in IDLE, decoded, then run through one or two
//   execute/write-back pass pairs that drive the ALU, register file and stack
//   memory strobes.
//
//   Optional feature: define EXEC_SEQ_TRAP_EN to halt on an illegal opcode
//   (TRAP state plus the trap output). Without it an illegal opcode retires
//   as a NOP straight out of DECODE.
//
// Parameters
//   CNT_W       width of the retired-instruction counter (default 16)
// Ports
//   clock       rising-edge clock for all state
//   reset       asynchronous, active-high reset
//   ope_valid   an instruction word is offered on ope
//   ope[31:0]   instruction word, opcode in ope[31:24]
//   ope_ready   sequencer is idle and can accept an opcode
//   alu_strobe  one-cycle ALU execute pulse (EXEC1/EXEC2)
//   pass        0 during the first pass, 1 during the second
//   reg_we      one-cycle register write pulse
//   reg_sel     destination register: 0 none, 1 esp, 2 ebp, 3 eax, 4 eip
//   mem_we      stack store pulse
//   mem_re      stack load pulse
//   done        one-cycle instruction-complete pulse
//   trap        illegal-opcode halt flag (EXEC_SEQ_TRAP_EN only)
//   retired     count of completed instructions, wraps to 0

module exec_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ope_valid,
  input  logic [31:0]      ope,
  output logic             ope_ready,
  output logic             alu_strobe,
  output logic             pass,
  output logic             reg_we,
  output logic [2:0]       reg_sel,
  output logic             mem_we,
  output logic             mem_re,
  output logic             done,
`ifdef EXEC_SEQ_TRAP_EN
  output logic             trap,
`endif
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] OP_PUSH    = 8'h55;
  localparam logic [7:0] OP_MOV_EBP = 8'h89;
  localparam logic [7:0] OP_MOV_EAX = 8'hb8;
  localparam logic [7:0] OP_POP     = 8'h5d;
  localparam logic [7:0] OP_RET     = 8'hc3;
  localparam logic [7:0] OP_CALL    = 8'he8;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_ESP  = 3'd1;
  localparam logic [2:0] SEL_EBP  = 3'd2;
  localparam logic [2:0] SEL_EAX  = 3'd3;
  localparam logic [2:0] SEL_EIP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC1,
    WB1,
    EXEC2,
    WB2
`ifdef EXEC_SEQ_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] opcode;

  // Per-opcode attributes, derived from the latched opcode byte
  logic       is_known;
  logic       is_two_pass;
  logic [2:0] sel_p0;
  logic [2:0] sel_p1;
  logic       load_p0;
  logic       store_p1;

  // Only the opcode byte matters; the operand bits are deliberately dropped
  logic unused_ope_bits;
  assign unused_ope_bits = ^ope[23:0];

  // Opcode attribute table. Push/call adjust esp first and store second;
  // pop/ret load first (ebp/eip) and bump esp second; the movs are one pass.
  always_comb begin
    is_known    = 1'b0;
    is_two_pass = 1'b0;
    sel_p0      = SEL_NONE;
    sel_p1      = SEL_NONE;
    load_p0     = 1'b0;
    store_p1    = 1'b0;
    case (opcode)
      OP_PUSH, OP_CALL: begin
        is_known    = 1'b1;
        is_two_pass = 1'b1;
        sel_p0      = SEL_ESP;
        store_p1    = 1'b1;
      end
      OP_POP: begin
        is_known    = 1'b1;
        is_two_pass = 1'b1;
        sel_p0      = SEL_EBP;
        load_p0     = 1'b1;
        sel_p1      = SEL_ESP;
      end
      OP_RET: begin
        is_known    = 1'b1;
        is_two_pass = 1'b1;
        sel_p0      = SEL_EIP;
        load_p0     = 1'b1;
        sel_p1      = SEL_ESP;
      end
      OP_MOV_EBP: begin
        is_known = 1'b1;
        sel_p0   = SEL_EBP;
      end
      OP_MOV_EAX: begin
        is_known = 1'b1;
        sel_p0   = SEL_EAX;
      end
      default: ;
    endcase
  end

  // Next-state and output decode. All outputs are pure functions of the
  // state, so the async reset clears them the instant state returns to IDLE.
  always_comb begin
    next_state = state;
    ope_ready  = 1'b0;
    alu_strobe = 1'b0;
    pass       = 1'b0;
    reg_sel    = SEL_NONE;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ope_ready = ~reset;
        if (ope_valid) next_state = DECODE;
      end
      DECODE: begin
        if (is_known) begin
          next_state = EXEC1;
        end else begin
`ifdef EXEC_SEQ_TRAP_EN
          next_state = TRAP;
`else
          done       = 1'b1;
          next_state = IDLE;
`endif
        end
      end
      EXEC1: begin
        alu_strobe = 1'b1;
        reg_sel    = sel_p0;
        next_state = WB1;
      end
      WB1: begin
        reg_sel = sel_p0;
        reg_we  = (sel_p0 != SEL_NONE);
        mem_re  = load_p0;
        if (is_two_pass) begin
          next_state = EXEC2;
        end else begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      EXEC2: begin
        alu_strobe = 1'b1;
        pass       = 1'b1;
        reg_sel    = sel_p1;
        next_state = WB2;
      end
      WB2: begin
        pass       = 1'b1;
        reg_sel    = sel_p1;
        reg_we     = (sel_p1 != SEL_NONE);
        mem_we     = store_p1;
        done       = 1'b1;
        next_state = IDLE;
      end
`ifdef EXEC_SEQ_TRAP_EN
      TRAP: begin
        next_state = TRAP;
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef EXEC_SEQ_TRAP_EN
  assign trap = (state == TRAP);
`endif

  // State, opcode latch and retired counter. The counter only moves on a
  // done pulse, so an instruction aborted by reset never counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      opcode  <= 8'h00;
      retired <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && ope_valid) opcode <= ope[31:24];
      if (done) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer
//   Directed bench for exec_sequencer. The stimulus side pushes the expected
//   strobe events of each instruction (cycle, strobes, reg_sel, retired) into
//   a queue; an independent monitor pops and compares on every cycle in which
//   the DUT shows any strobe. A second instance with CNT_W=4 covers counter
//   wrap. Builds with or without EXEC_SEQ_TRAP_EN.

module tb_exec_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        ope_valid;
  logic [31:0] ope;
  logic        ope_ready;
  logic        alu_strobe;
  logic        pass;
  logic        reg_we;
  logic [2:0]  reg_sel;
  logic        mem_we;
  logic        mem_re;
  logic        done;
  logic [15:0] retired;
`ifdef EXEC_SEQ_TRAP_EN
  logic        trap;
  logic        trap4;
`endif

  logic        ope_valid4;
  logic [31:0] ope4;
  logic        ope_ready4;
  logic        alu_strobe4;
  logic        pass4;
  logic        reg_we4;
  logic [2:0]  reg_sel4;
  logic        mem_we4;
  logic        mem_re4;
  logic        done4;
  logic [3:0]  retired4;

  exec_sequencer #(.CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .ope_valid  (ope_valid),
    .ope        (ope),
    .ope_ready  (ope_ready),
    .alu_strobe (alu_strobe),
    .pass       (pass),
    .reg_we     (reg_we),
    .reg_sel    (reg_sel),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .done       (done),
`ifdef EXEC_SEQ_TRAP_EN
    .trap       (trap),
`endif
    .retired    (retired)
  );

  exec_sequencer #(.CNT_W(4)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .ope_valid  (ope_valid4),
    .ope        (ope4),
    .ope_ready  (ope_ready4),
    .alu_strobe (alu_strobe4),
    .pass       (pass4),
    .reg_we     (reg_we4),
    .reg_sel    (reg_sel4),
    .mem_we     (mem_we4),
    .mem_re     (mem_re4),
    .done       (done4),
`ifdef EXEC_SEQ_TRAP_EN
    .trap       (trap4),
`endif
    .retired    (retired4)
  );

  // Cycle index: bumped on every rising edge, read at falling edges
  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct packed {
    logic        alu;
    logic        pas;
    logic [2:0]  sel;
    logic        rwe;
    logic        mwe;
    logic        mre;
    logic        dne;
    logic [15:0] ret;
  } ev_t;

  typedef struct {
    int  c;
    ev_t ev;
  } exp_t;

  exp_t        sb_q[$];
  int          n_compared = 0;
  int          n_failed   = 0;
  logic [15:0] exp_ret    = 16'd0;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_ev(input int c, input logic alu, input logic pas,
                         input logic [2:0] sel, input logic rwe, input logic mwe,
                         input logic mre, input logic dne);
    exp_t e;
    e.c  = c;
    e.ev = {alu, pas, sel, rwe, mwe, mre, dne, exp_ret};
    sb_q.push_back(e);
  endtask

  // Offer an opcode at the current falling edge; the next rising edge is the
  // acceptance edge 'acc'. Expected strobe events are hand-listed per opcode.
  task automatic apply_stimulus(input logic [7:0] op, input bit hold, output int acc);
    ope_valid = 1'b1;
    ope       = {op, 24'h123456};
    acc       = cyc + 1;
    case (op)
      8'hb8: begin
        push_ev(acc+1, 1, 0, 3'd3, 0, 0, 0, 0);
        push_ev(acc+2, 0, 0, 3'd3, 1, 0, 0, 1);
        exp_ret++;
      end
      8'h89: begin
        push_ev(acc+1, 1, 0, 3'd2, 0, 0, 0, 0);
        push_ev(acc+2, 0, 0, 3'd2, 1, 0, 0, 1);
        exp_ret++;
      end
      8'h55, 8'he8: begin
        push_ev(acc+1, 1, 0, 3'd1, 0, 0, 0, 0);
        push_ev(acc+2, 0, 0, 3'd1, 1, 0, 0, 0);
        push_ev(acc+3, 1, 1, 3'd0, 0, 0, 0, 0);
        push_ev(acc+4, 0, 1, 3'd0, 0, 1, 0, 1);
        exp_ret++;
      end
      8'h5d: begin
        push_ev(acc+1, 1, 0, 3'd2, 0, 0, 0, 0);
        push_ev(acc+2, 0, 0, 3'd2, 1, 0, 1, 0);
        push_ev(acc+3, 1, 1, 3'd1, 0, 0, 0, 0);
        push_ev(acc+4, 0, 1, 3'd1, 1, 0, 0, 1);
        exp_ret++;
      end
      8'hc3: begin
        push_ev(acc+1, 1, 0, 3'd4, 0, 0, 0, 0);
        push_ev(acc+2, 0, 0, 3'd4, 1, 0, 1, 0);
        push_ev(acc+3, 1, 1, 3'd1, 0, 0, 0, 0);
        push_ev(acc+4, 0, 1, 3'd1, 1, 0, 0, 1);
        exp_ret++;
      end
      default: begin
`ifndef EXEC_SEQ_TRAP_EN
        push_ev(acc, 0, 0, 3'd0, 0, 0, 0, 1);
        exp_ret++;
`endif
      end
    endcase
    if (!hold) begin
      @(negedge clock);
      ope_valid = 1'b0;
    end
  endtask

  task automatic wait_until(input int c);
    for (int k = 0; k < 200 && cyc < c; k++) @(negedge clock);
    if (cyc != c) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL wait_until: got cycle %0d expected %0d", cyc, c);
    end
  endtask

  // Monitor: any strobe is an event that must match the head of the queue
  always @(negedge clock) begin
    ev_t  act;
    exp_t e;
    if (!reset && (alu_strobe || reg_we || mem_we || mem_re || done)) begin
      act = {alu_strobe, pass, reg_sel, reg_we, mem_we, mem_re, done, retired};
      n_compared++;
      if (sb_q.size() == 0) begin
        n_failed++;
        $display("[TB] FAIL unexpected_event: got cyc=%0d ev=%h expected no event",
                 cyc, act);
      end else begin
        e = sb_q.pop_front();
        if (e.c != cyc || e.ev !== act) begin
          n_failed++;
          $display("[TB] FAIL event: got cyc=%0d ev=%h expected cyc=%0d ev=%h",
                   cyc, act, e.c, e.ev);
        end
      end
    end
  end

  initial begin
    int a;
    int a2;
    int n4;
    reset      = 1'b1;
    ope_valid  = 1'b0;
    ope        = 32'h0;
    ope_valid4 = 1'b0;
    ope4       = 32'h0;

    // Reset state
    repeat (2) @(negedge clock);
    check_output("ready_in_reset", {31'd0, ope_ready}, 32'd0);
    check_output("retired_in_reset", {16'd0, retired}, 32'd0);
    check_output("sel_in_reset", {29'd0, reg_sel}, 32'd0);
    reset = 1'b0;
    #1;
    check_output("ready_after_reset", {31'd0, ope_ready}, 32'd1);

    // b8 accepted on the first edge after reset release
    apply_stimulus(8'hb8, 1'b0, a);
    check_output("b8_busy", {31'd0, ope_ready}, 32'd0);
    wait_until(a + 3);
    check_output("b8_retired", {16'd0, retired}, 32'd1);
    check_output("b8_ready_again", {31'd0, ope_ready}, 32'd1);

    // 55 at the earliest slot; busy for five cycles, pass high in pass two
    apply_stimulus(8'h55, 1'b0, a);
    for (int k = 0; k < 5; k++) begin
      wait_until(a + k);
      check_output("push_busy", {31'd0, ope_ready}, 32'd0);
      check_output("push_pass", {31'd0, pass}, (k >= 3) ? 32'd1 : 32'd0);
    end
    wait_until(a + 5);
    check_output("push_ready_again", {31'd0, ope_ready}, 32'd1);
    check_output("push_retired", {16'd0, retired}, 32'd2);

    // c3 then 5d with ope_valid held; 5d sits on ope while c3 runs
    apply_stimulus(8'hc3, 1'b1, a);
    @(negedge clock);
    ope = {8'h5d, 24'h0};
    wait_until(a + 5);
    apply_stimulus(8'h5d, 1'b0, a2);
    check_output("pop_accept_slot", a2, a + 6);
    wait_until(a2 + 5);
    check_output("ret_pop_retired", {16'd0, retired}, 32'd4);

    // Unknown opcode 90
    apply_stimulus(8'h90, 1'b0, a);
    wait_until(a + 1);
`ifdef EXEC_SEQ_TRAP_EN
    check_output("trap_set", {31'd0, trap}, 32'd1);
    check_output("trap_retired", {16'd0, retired}, 32'd4);
    ope_valid = 1'b1;
    ope       = {8'hb8, 24'h0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_output("trap_held", {31'd0, trap}, 32'd1);
      check_output("trap_not_ready", {31'd0, ope_ready}, 32'd0);
    end
    ope_valid = 1'b0;
`else
    check_output("nop_retired", {16'd0, retired}, 32'd5);
    check_output("nop_ready", {31'd0, ope_ready}, 32'd1);
`endif
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_output("retired_cleared", {16'd0, retired}, 32'd0);
`ifdef EXEC_SEQ_TRAP_EN
    check_output("trap_cleared", {31'd0, trap}, 32'd0);
`endif
    @(negedge clock);
    reset   = 1'b0;
    exp_ret = 16'd0;

    // e8 aborted by reset in EXEC2: its WB2 event must never appear
    apply_stimulus(8'he8, 1'b0, a);
    void'(sb_q.pop_back());
    exp_ret--;
    wait_until(a + 3);
    #1;
    reset = 1'b1;
    #1;
    check_output("abort_outputs",
                 {22'd0, alu_strobe, pass, reg_we, reg_sel, mem_we, mem_re, done, ope_ready},
                 32'd0);
    check_output("abort_retired", {16'd0, retired}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_output("abort_ready_after", {31'd0, ope_ready}, 32'd1);
    repeat (6) @(negedge clock);
    check_output("abort_retired_later", {16'd0, retired}, 32'd0);
    check_output("queue_drained", sb_q.size(), 32'd0);

    // CNT_W=4 instance: fifteen b8, then an 89 wraps the counter
    ope_valid4 = 1'b1;
    ope4       = {8'hb8, 24'h0};
    n4 = 0;
    for (int k = 0; k < 200 && n4 < 15; k++) begin
      @(negedge clock);
      if (done4) n4++;
    end
    check_output("wrap_b8_count", n4, 32'd15);
    ope4 = {8'h89, 24'h0};
    @(negedge clock);
    check_output("wrap_preload", {28'd0, retired4}, 32'd15);
    n4 = 0;
    for (int k = 0; k < 20 && n4 < 1; k++) begin
      @(negedge clock);
      if (done4) n4++;
    end
    check_output("wrap_89_done", n4, 32'd1);
    check_output("wrap_89_sel", {29'd0, reg_sel4}, 32'd2);
    ope_valid4 = 1'b0;
    @(negedge clock);
    check_output("wrap_retired", {28'd0, retired4}, 32'd0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
